// File: rtl/mc_control_fsm.sv
//------------------------------------------------------------------------------
// Module      : mc_control_fsm
// Description : Control sequencer for a multicycle MIPS datapath with a shared
//               ALU and a shared memory. It decodes opcode/funct, drives one
//               control-state per cycle, stalls memory states until mem_ready
//               and counts retired instructions.
// Ports       : ck          clock, rising edge
//               rt          asynchronous active-low reset; also gates outputs
//               opcode[5:0] instr[31:26] from the instruction register
//               funct[5:0]  instr[5:0] from the instruction register
//               mem_ready   memory ack (read data valid / write done)
//               mem_req, MemWrite, IorD, IRWrite, RegDst, MemtoReg, ALUSrcA,
//               RegWrite, PCWrite, Branch            1-bit datapath controls
//               ALUSrcB[1:0] 00 B, 01 +4, 10 signext, 11 signext<<2
//               PCSrc[1:0]   00 ALU result, 01 ALUout, 10 jump target
//               ALUcontrole[2:0] 010 add, 110 sub, 000 and, 001 or, 111 slt
//               illegal     one-cycle pulse on unsupported opcode/funct
//               retired[CNT_W-1:0] retired-instruction count (wraps)
// Config      : ADDI_EN  when defined, opcode 001000 (addi) is executed;
//               otherwise it is reported as illegal.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mc_control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             ck,
  input  logic             rt,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             MemWrite,
  output logic             IorD,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             ALUSrcA,
  output logic             RegWrite,
  output logic             PCWrite,
  output logic             Branch,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSrc,
  output logic [2:0]       ALUcontrole,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  // Opcodes
  localparam logic [5:0] c_OP_R    = 6'b000000;
  localparam logic [5:0] c_OP_J    = 6'b000010;
  localparam logic [5:0] c_OP_BEQ  = 6'b000100;
  localparam logic [5:0] c_OP_LW   = 6'b100011;
  localparam logic [5:0] c_OP_SW   = 6'b101011;
`ifdef ADDI_EN
  localparam logic [5:0] c_OP_ADDI = 6'b001000;
`endif

  // R-type function codes
  localparam logic [5:0] c_FN_ADD  = 6'b100000;
  localparam logic [5:0] c_FN_SUB  = 6'b100010;
  localparam logic [5:0] c_FN_AND  = 6'b100100;
  localparam logic [5:0] c_FN_OR   = 6'b100101;
  localparam logic [5:0] c_FN_SLT  = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] c_ALU_ADD = 3'b010;
  localparam logic [2:0] c_ALU_SUB = 3'b110;
  localparam logic [2:0] c_ALU_AND = 3'b000;
  localparam logic [2:0] c_ALU_OR  = 3'b001;
  localparam logic [2:0] c_ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQEX  = 4'd8,
    S_JEX    = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  // Decode helpers
  logic             w_op_legal;
  state_t           w_op_next;
  logic             w_fn_legal;
  logic [2:0]       w_fn_alu;
  logic             w_retire;

  // Ungated control decodes
  logic             w_mem_req, w_memwrite, w_iord, w_irwrite, w_regdst;
  logic             w_memtoreg, w_alusrca, w_regwrite, w_pcwrite, w_branch;
  logic [1:0]       w_alusrcb, w_pcsrc;
  logic [2:0]       w_aluctl;
  logic             w_illegal;

  //--------------------------------------------------------------------------
  // Opcode decode: successor of DECODE and legality of the opcode.
  //--------------------------------------------------------------------------
  always_comb begin
    w_op_legal = 1'b1;
    w_op_next  = S_FETCH;
    case (opcode)
      c_OP_LW,
      c_OP_SW:   w_op_next = S_MEMADR;
      c_OP_R:    w_op_next = S_REXEC;
      c_OP_BEQ:  w_op_next = S_BEQEX;
      c_OP_J:    w_op_next = S_JEX;
`ifdef ADDI_EN
      c_OP_ADDI: w_op_next = S_ADDIEX;
`endif
      default:   w_op_legal = 1'b0;
    endcase
  end

  //--------------------------------------------------------------------------
  // Funct decode for R-type execution.
  //--------------------------------------------------------------------------
  always_comb begin
    w_fn_legal = 1'b1;
    w_fn_alu   = c_ALU_AND;
    case (funct)
      c_FN_ADD: w_fn_alu = c_ALU_ADD;
      c_FN_SUB: w_fn_alu = c_ALU_SUB;
      c_FN_AND: w_fn_alu = c_ALU_AND;
      c_FN_OR:  w_fn_alu = c_ALU_OR;
      c_FN_SLT: w_fn_alu = c_ALU_SLT;
      default:  w_fn_legal = 1'b0;
    endcase
  end

  //--------------------------------------------------------------------------
  // Next-state logic. w_retire marks the final cycle of a legal instruction.
  //--------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    w_retire = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = w_op_legal ? w_op_next : S_FETCH;
      // Only lw/sw reach MEMADR, so the store opcode alone selects the path.
      S_MEMADR: state_d = (opcode == c_OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB: begin
        state_d  = S_FETCH;
        w_retire = 1'b1;
      end
      S_MEMWR: begin
        if (mem_ready) begin
          state_d  = S_FETCH;
          w_retire = 1'b1;
        end
      end
      S_REXEC:  state_d = w_fn_legal ? S_ALUWB : S_FETCH;
      S_ALUWB,
      S_BEQEX,
      S_JEX,
      S_ADDIWB: begin
        state_d  = S_FETCH;
        w_retire = 1'b1;
      end
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Natural binary wrap gives the modulo-2**CNT_W behaviour.
  always_comb begin
    retired_d = retired_q;
    if (w_retire) retired_d = retired_q + CNT_W'(1);
  end

  //--------------------------------------------------------------------------
  // State and counter registers.
  //--------------------------------------------------------------------------
  always_ff @(posedge ck or negedge rt) begin
    if (!rt) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  //--------------------------------------------------------------------------
  // Control decode. Moore on state, except the FETCH register enables, which
  // follow mem_ready so IR and PC load only in the acknowledged cycle, and the
  // illegal flag, which reflects the instruction field currently being decoded.
  // Kept combinational because both of those must act in the same cycle.
  //--------------------------------------------------------------------------
  always_comb begin
    w_mem_req  = 1'b0;
    w_memwrite = 1'b0;
    w_iord     = 1'b0;
    w_irwrite  = 1'b0;
    w_regdst   = 1'b0;
    w_memtoreg = 1'b0;
    w_alusrca  = 1'b0;
    w_regwrite = 1'b0;
    w_pcwrite  = 1'b0;
    w_branch   = 1'b0;
    w_alusrcb  = 2'b00;
    w_pcsrc    = 2'b00;
    w_aluctl   = c_ALU_AND;
    w_illegal  = 1'b0;
    case (state_q)
      S_FETCH: begin
        w_mem_req = 1'b1;
        w_alusrcb = 2'b01;
        w_aluctl  = c_ALU_ADD;
        w_irwrite = mem_ready;
        w_pcwrite = mem_ready;
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUout.
        w_alusrcb = 2'b11;
        w_aluctl  = c_ALU_ADD;
        w_illegal = ~w_op_legal;
      end
      S_MEMADR,
      S_ADDIEX: begin
        w_alusrca = 1'b1;
        w_alusrcb = 2'b10;
        w_aluctl  = c_ALU_ADD;
      end
      S_MEMRD: begin
        w_mem_req = 1'b1;
        w_iord    = 1'b1;
      end
      S_MEMWB: begin
        w_memtoreg = 1'b1;
        w_regwrite = 1'b1;
      end
      S_MEMWR: begin
        w_mem_req  = 1'b1;
        w_iord     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_REXEC: begin
        w_alusrca = 1'b1;
        w_aluctl  = w_fn_alu;
        w_illegal = ~w_fn_legal;
      end
      S_ALUWB: begin
        w_regdst   = 1'b1;
        w_regwrite = 1'b1;
      end
      S_BEQEX: begin
        w_alusrca = 1'b1;
        w_aluctl  = c_ALU_SUB;
        w_branch  = 1'b1;
        w_pcsrc   = 2'b01;
      end
      S_JEX: begin
        w_pcwrite = 1'b1;
        w_pcsrc   = 2'b10;
      end
      S_ADDIWB: begin
        w_regwrite = 1'b1;
      end
      default: begin
        w_mem_req = 1'b0;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Output gating: while rt is low every control line is forced to 0 at once,
  // so a reset in the middle of a write cannot leave a partial strobe behind.
  //--------------------------------------------------------------------------
  assign mem_req     = rt & w_mem_req;
  assign MemWrite    = rt & w_memwrite;
  assign IorD        = rt & w_iord;
  assign IRWrite     = rt & w_irwrite;
  assign RegDst      = rt & w_regdst;
  assign MemtoReg    = rt & w_memtoreg;
  assign ALUSrcA     = rt & w_alusrca;
  assign RegWrite    = rt & w_regwrite;
  assign PCWrite     = rt & w_pcwrite;
  assign Branch      = rt & w_branch;
  assign ALUSrcB     = rt ? w_alusrcb : 2'b00;
  assign PCSrc       = rt ? w_pcsrc   : 2'b00;
  assign ALUcontrole = rt ? w_aluctl  : 3'b000;
  assign illegal     = rt & w_illegal;
  assign retired     = rt ? retired_q : '0;

endmodule

`default_nettype wire

// File: tb/tb_mc_control_fsm.sv
//------------------------------------------------------------------------------
// Module      : tb_mc_control_fsm
// Description : Directed self-checking bench for mc_control_fsm. A second
//               instance with a 2-bit counter follows the same stimulus so the
//               retired-count wrap is reached within a short run.
// Revision    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mc_control_fsm;

  logic        ck;
  logic        rt;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        mem_ready;

  logic        mem_req, MemWrite, IorD, IRWrite, RegDst, MemtoReg;
  logic        ALUSrcA, RegWrite, PCWrite, Branch, illegal;
  logic [1:0]  ALUSrcB, PCSrc;
  logic [2:0]  ALUcontrole;
  logic [15:0] retired;

  logic        n_mem_req, n_MemWrite, n_IorD, n_IRWrite, n_RegDst, n_MemtoReg;
  logic        n_ALUSrcA, n_RegWrite, n_PCWrite, n_Branch, n_illegal;
  logic [1:0]  n_ALUSrcB, n_PCSrc;
  logic [2:0]  n_ALUcontrole;
  logic [1:0]  n_retired;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ret  = 0;

  mc_control_fsm #(.CNT_W(16)) dut (
    .ck(ck), .rt(rt), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .PCWrite(PCWrite), .Branch(Branch),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUcontrole(ALUcontrole),
    .illegal(illegal), .retired(retired)
  );

  mc_control_fsm #(.CNT_W(2)) u_narrow (
    .ck(ck), .rt(rt), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .mem_req(n_mem_req), .MemWrite(n_MemWrite), .IorD(n_IorD),
    .IRWrite(n_IRWrite), .RegDst(n_RegDst), .MemtoReg(n_MemtoReg),
    .ALUSrcA(n_ALUSrcA), .RegWrite(n_RegWrite), .PCWrite(n_PCWrite),
    .Branch(n_Branch), .ALUSrcB(n_ALUSrcB), .PCSrc(n_PCSrc),
    .ALUcontrole(n_ALUcontrole), .illegal(n_illegal), .retired(n_retired)
  );

  // Field order: mem_req MemWrite IorD IRWrite RegDst MemtoReg ALUSrcA
  //              RegWrite PCWrite Branch | ALUSrcB | PCSrc | ALUcontrole | illegal
  logic [17:0] ctl_obs, n_ctl_obs;
  assign ctl_obs   = {mem_req, MemWrite, IorD, IRWrite, RegDst, MemtoReg,
                      ALUSrcA, RegWrite, PCWrite, Branch, ALUSrcB, PCSrc,
                      ALUcontrole, illegal};
  assign n_ctl_obs = {n_mem_req, n_MemWrite, n_IorD, n_IRWrite, n_RegDst,
                      n_MemtoReg, n_ALUSrcA, n_RegWrite, n_PCWrite, n_Branch,
                      n_ALUSrcB, n_PCSrc, n_ALUcontrole, n_illegal};

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  function automatic logic [17:0] pk(input logic [9:0] flags, input logic [1:0] asb,
                                     input logic [1:0] pcs, input logic [2:0] alu,
                                     input logic ill);
    return {flags, asb, pcs, alu, ill};
  endfunction

  logic [17:0] E_ZERO, E_FETCH, E_STALL, E_DEC, E_DEC_ILL, E_MEMADR, E_MEMRD;
  logic [17:0] E_MEMWB, E_MEMWR, E_REX_ILL, E_ALUWB, E_BEQ, E_JEX, E_ADDIWB;

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Drive inputs just after the edge, check combinational outputs, advance.
  task automatic step(input string tag, input logic [5:0] op, input logic [5:0] fn,
                      input logic mr, input logic [17:0] exp);
    opcode    = op;
    funct     = fn;
    mem_ready = mr;
    #1;
    check_eq(tag, 32'(ctl_obs), 32'(exp));
    check_eq({tag, "_n"}, 32'(n_ctl_obs), 32'(exp));
    @(posedge ck);
    #1;
  endtask

  task automatic check_ret(input string tag);
    check_eq(tag, 32'(retired), 32'(exp_ret));
    check_eq({tag, "_n"}, 32'(n_retired), 32'(exp_ret % 4));
  endtask

  function automatic logic [17:0] rex(input logic [2:0] alu);
    return pk(10'b00000_01000, 2'b00, 2'b00, alu, 1'b0);
  endfunction

  task automatic run_r(input string tag, input logic [5:0] fn, input logic [2:0] alu);
    step({tag, "_fetch"}, OP_R, fn, 1'b1, E_FETCH);
    step({tag, "_dec"},   OP_R, fn, 1'b1, E_DEC);
    step({tag, "_rex"},   OP_R, fn, 1'b1, rex(alu));
    step({tag, "_wb"},    OP_R, fn, 1'b1, E_ALUWB);
    exp_ret++;
    check_ret({tag, "_ret"});
  endtask

  initial begin
    E_ZERO    = '0;
    E_FETCH   = pk(10'b10010_00010, 2'b01, 2'b00, 3'b010, 1'b0);
    E_STALL   = pk(10'b10000_00000, 2'b01, 2'b00, 3'b010, 1'b0);
    E_DEC     = pk(10'b00000_00000, 2'b11, 2'b00, 3'b010, 1'b0);
    E_DEC_ILL = pk(10'b00000_00000, 2'b11, 2'b00, 3'b010, 1'b1);
    E_MEMADR  = pk(10'b00000_01000, 2'b10, 2'b00, 3'b010, 1'b0);
    E_MEMRD   = pk(10'b10100_00000, 2'b00, 2'b00, 3'b000, 1'b0);
    E_MEMWB   = pk(10'b00000_10100, 2'b00, 2'b00, 3'b000, 1'b0);
    E_MEMWR   = pk(10'b11100_00000, 2'b00, 2'b00, 3'b000, 1'b0);
    E_REX_ILL = pk(10'b00000_01000, 2'b00, 2'b00, 3'b000, 1'b1);
    E_ALUWB   = pk(10'b00001_00100, 2'b00, 2'b00, 3'b000, 1'b0);
    E_BEQ     = pk(10'b00000_01001, 2'b00, 2'b01, 3'b110, 1'b0);
    E_JEX     = pk(10'b00000_00010, 2'b00, 2'b10, 3'b000, 1'b0);
    E_ADDIWB  = pk(10'b00000_00100, 2'b00, 2'b00, 3'b000, 1'b0);

    // Reset held for three cycles with mem_ready high.
    rt = 1'b0; mem_ready = 1'b1; opcode = OP_LW; funct = 6'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge ck); #1;
      check_eq("rst_ctl", 32'(ctl_obs), 32'(E_ZERO));
      check_ret("rst_ret");
    end
    rt = 1'b1;

    // lw, memory always ready: five cycles.
    step("lw_fetch",  OP_LW, 6'b0, 1'b1, E_FETCH);
    step("lw_dec",    OP_LW, 6'b0, 1'b1, E_DEC);
    step("lw_memadr", OP_LW, 6'b0, 1'b1, E_MEMADR);
    step("lw_memrd",  OP_LW, 6'b0, 1'b1, E_MEMRD);
    check_ret("lw_ret_pre");
    step("lw_memwb",  OP_LW, 6'b0, 1'b1, E_MEMWB);
    exp_ret = 1;
    check_ret("lw_ret");

    // Fetch stall for four cycles, then ack, then R add.
    for (int i = 0; i < 4; i++) step("stall_fetch", OP_R, 6'b100000, 1'b0, E_STALL);
    step("add_fetch", OP_R, 6'b100000, 1'b1, E_FETCH);
    step("add_dec",   OP_R, 6'b100000, 1'b1, E_DEC);
    step("add_rex",   OP_R, 6'b100000, 1'b1, rex(3'b010));
    step("add_wb",    OP_R, 6'b100000, 1'b1, E_ALUWB);
    exp_ret = 2;
    check_ret("add_ret");

    // beq.
    step("beq_fetch", OP_BEQ, 6'b0, 1'b1, E_FETCH);
    step("beq_dec",   OP_BEQ, 6'b0, 1'b1, E_DEC);
    step("beq_ex",    OP_BEQ, 6'b0, 1'b1, E_BEQ);
    exp_ret = 3;
    check_ret("beq_ret");

    // sw with one wait cycle in MEMWR; narrow counter wraps 3 -> 0 here.
    step("sw_fetch",  OP_SW, 6'b0, 1'b1, E_FETCH);
    step("sw_dec",    OP_SW, 6'b0, 1'b1, E_DEC);
    step("sw_memadr", OP_SW, 6'b0, 1'b1, E_MEMADR);
    step("sw_wait",   OP_SW, 6'b0, 1'b0, E_MEMWR);
    check_ret("sw_ret_wait");
    step("sw_memwr",  OP_SW, 6'b0, 1'b1, E_MEMWR);
    exp_ret = 4;
    check_ret("sw_ret");

    // Remaining R-type operations.
    run_r("sub", 6'b100010, 3'b110);
    run_r("and", 6'b100100, 3'b000);
    run_r("or",  6'b100101, 3'b001);
    run_r("slt", 6'b101010, 3'b111);

    // Illegal opcode and illegal funct: one pulse each, count unchanged.
    step("badop_fetch", OP_BAD, 6'b0, 1'b1, E_FETCH);
    step("badop_dec",   OP_BAD, 6'b0, 1'b1, E_DEC_ILL);
    check_ret("badop_ret");
    step("badfn_fetch", OP_R, 6'b000111, 1'b1, E_FETCH);
    step("badfn_dec",   OP_R, 6'b000111, 1'b1, E_DEC);
    step("badfn_rex",   OP_R, 6'b000111, 1'b1, E_REX_ILL);
    check_ret("badfn_ret");

    // addi: executed or rejected depending on the build.
    step("addi_fetch", OP_ADDI, 6'b0, 1'b1, E_FETCH);
`ifdef ADDI_EN
    step("addi_dec",   OP_ADDI, 6'b0, 1'b1, E_DEC);
    step("addi_ex",    OP_ADDI, 6'b0, 1'b1, E_MEMADR);
    step("addi_wb",    OP_ADDI, 6'b0, 1'b1, E_ADDIWB);
    exp_ret++;
`else
    step("addi_dec",   OP_ADDI, 6'b0, 1'b1, E_DEC_ILL);
`endif
    check_ret("addi_ret");

    // j.
    step("j_fetch", OP_J, 6'b0, 1'b1, E_FETCH);
    step("j_dec",   OP_J, 6'b0, 1'b1, E_DEC);
    step("j_ex",    OP_J, 6'b0, 1'b1, E_JEX);
    exp_ret++;
    check_ret("j_ret");

    // Reset asserted while a store is waiting in MEMWR.
    step("rsw_fetch",  OP_SW, 6'b0, 1'b1, E_FETCH);
    step("rsw_dec",    OP_SW, 6'b0, 1'b1, E_DEC);
    step("rsw_memadr", OP_SW, 6'b0, 1'b1, E_MEMADR);
    step("rsw_wait",   OP_SW, 6'b0, 1'b0, E_MEMWR);
    check_eq("rsw_memwrite_pre", 32'(MemWrite), 32'd1);
    rt = 1'b0;
    #1;
    check_eq("rsw_memwrite_rst", 32'(MemWrite), 32'd0);
    check_eq("rsw_ctl_rst", 32'(ctl_obs), 32'(E_ZERO));
    exp_ret = 0;
    check_ret("rsw_ret_rst");
    @(posedge ck); #1;
    rt = 1'b1;
    step("post_rst_fetch", OP_J, 6'b0, 1'b1, E_FETCH);
    step("post_rst_dec",   OP_J, 6'b0, 1'b1, E_DEC);
    check_ret("post_rst_ret");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
